// File: rtl/idli_sqi_pkg.sv
// Shared types and constants for the idli SQI serial-SRAM controller.
package idli_sqi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_GAP
  } sqi_state_e;

  // Half of a nibble slot: LOW = controller updates SIO, HIGH = SRAM samples.
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } sck_phase_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int NIB_CNT_W = 3;
  localparam logic [NIB_CNT_W-1:0] CMD_LAST  = 3'd1;  // 2 command nibbles
  localparam logic [NIB_CNT_W-1:0] DATA_LAST = 3'd3;  // 4 data nibbles

  // Core words are little-endian on the wire: low byte goes out first.
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// 16-bit nibble shifter: parallel load, MSB nibble is the outgoing nibble,
// incoming nibble enters at the bottom. Serves both TX and RX paths.
module idli_sqi_shift_m (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift,
  input  logic [3:0]  shift_in,
  output logic [15:0] q
);

  // Load wins over shift so a segment reload replaces the spent nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[11:0], shift_in};
  end

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// Quad-SPI master for a 23LC1024-class SRAM: one 16-bit word per request.
// Optional macro IDLI_SQI_BURST_EN adds i_sqi_req_cont for sequential-mode
// multi-word transfers while CS stays low.
module idli_sqi_ctrl_m
  import idli_sqi_pkg::*;
#(
  parameter int ADDR_NIBBLES  = 6,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_req_vld,
`ifdef IDLI_SQI_BURST_EN
  input  logic        i_sqi_req_cont,
`endif
  input  logic        i_sqi_req_wr,
  input  logic [15:0] i_sqi_req_addr,
  input  logic [15:0] i_sqi_req_wdata,
  output logic        o_sqi_req_acp,
  output logic [15:0] o_sqi_rdata,
  output logic        o_sqi_rdata_vld,
  output logic        o_sqi_mem_sck,
  output logic        o_sqi_mem_cs,
  output logic        o_sqi_mem_io_mode,
  input  logic [3:0]  i_sqi_mem_sio,
  output logic [3:0]  o_sqi_mem_sio
);

  localparam logic [NIB_CNT_W-1:0] ADDR_LAST   = NIB_CNT_W'(ADDR_NIBBLES - 1);
  // The first shifter load holds cmd + top address byte; the low 16 address
  // bits are reloaded once those two address nibbles have gone out.
  localparam logic [NIB_CNT_W-1:0] ADDR_RELOAD = NIB_CNT_W'(ADDR_NIBBLES - 5);
  localparam logic [NIB_CNT_W-1:0] DUMMY_LAST  = NIB_CNT_W'(DUMMY_NIBBLES - 1);

  sqi_state_e             state_q, state_d;
  sck_phase_e             phase_q;
  logic [NIB_CNT_W-1:0]   nib_q;
  logic                   wr_q;
  logic [14:0]            addr_lo_q;
  logic [15:0]            wdata_q;
  logic [15:0]            rdata_q;
  logic                   rdata_vld_q;

  logic                   cont;
  logic                   active, nib_end, accept, data_last;
  logic                   burst_wr, burst_go, seg_done, rd_turn;
  logic                   sh_load;
  logic [15:0]            sh_load_val, sh_q, rx_next;

`ifdef IDLI_SQI_BURST_EN
  assign cont = i_sqi_req_cont;
`else
  assign cont = 1'b0;
`endif

  // Transaction decode, next state and shifter control.
  always_comb begin
    active    = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                (state_q == ST_DUMMY) || (state_q == ST_DATA);
    nib_end   = active && (phase_q == PH_HIGH);
    accept    = i_sqi_req_vld && (state_q == ST_IDLE);
    data_last = (state_q == ST_DATA) && nib_end && (nib_q == DATA_LAST);
    // Write bursts need the next word in hand; read bursts only need cont.
    burst_wr  = data_last && cont && wr_q && i_sqi_req_vld;
    burst_go  = data_last && cont && (!wr_q || i_sqi_req_vld);

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CMD;
      ST_CMD:   if (nib_end && nib_q == CMD_LAST) state_d = ST_ADDR;
      ST_ADDR:  if (nib_end && nib_q == ADDR_LAST) state_d = wr_q ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (nib_end && nib_q == DUMMY_LAST) state_d = ST_DATA;
      ST_DATA:  if (data_last && !burst_go) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    seg_done = nib_end && ((state_d != state_q) || burst_go);

    sh_load     = 1'b0;
    sh_load_val = '0;
    if (accept) begin
      sh_load     = 1'b1;
      sh_load_val = {(i_sqi_req_wr ? CMD_WRITE : CMD_READ), 7'b0, i_sqi_req_addr[15]};
    end else if (state_q == ST_ADDR && nib_end && nib_q == ADDR_RELOAD) begin
      sh_load     = 1'b1;
      sh_load_val = {addr_lo_q, 1'b0};
    end else if (state_q == ST_ADDR && nib_end && nib_q == ADDR_LAST && wr_q) begin
      sh_load     = 1'b1;
      sh_load_val = byte_swap(wdata_q);
    end else if (burst_wr) begin
      sh_load     = 1'b1;
      sh_load_val = byte_swap(i_sqi_req_wdata);
    end

    rx_next = {sh_q[11:0], i_sqi_mem_sio};
  end

  idli_sqi_shift_m u_shift (
    .clk      (i_sqi_gck),
    .rst_n    (i_sqi_rst_n),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (nib_end),
    .shift_in (i_sqi_mem_sio),
    .q        (sh_q)
  );

  // State, phase toggle and per-segment nibble counter.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_LOW;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= (active && phase_q == PH_LOW) ? PH_HIGH : PH_LOW;
      if (seg_done)     nib_q <= '0;
      else if (nib_end) nib_q <= nib_q + 1'b1;
    end
  end

  // Request capture on accept (and on each burst write word).
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      wr_q      <= 1'b0;
      addr_lo_q <= '0;
      wdata_q   <= '0;
    end else if (accept) begin
      wr_q      <= i_sqi_req_wr;
      addr_lo_q <= i_sqi_req_addr[14:0];
      wdata_q   <= i_sqi_req_wdata;
    end else if (burst_wr) begin
      wdata_q   <= i_sqi_req_wdata;
    end
  end

  // Read word publish: the final nibble is folded in on the same edge it is sampled.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      rdata_vld_q <= data_last && !wr_q;
      if (data_last && !wr_q) rdata_q <= byte_swap(rx_next);
    end
  end

  // Pin drive is decoded from the async-reset state so CS drops out at once on reset.
  always_comb begin
    rd_turn           = !wr_q && ((state_q == ST_DUMMY) || (state_q == ST_DATA));
    o_sqi_req_acp     = accept || burst_wr;
    o_sqi_mem_cs      = !active;
    o_sqi_mem_sck     = active && (phase_q == PH_HIGH);
    o_sqi_mem_io_mode = !rd_turn;
    o_sqi_mem_sio     = (active && !rd_turn) ? sh_q[15:12] : 4'h0;
    o_sqi_rdata       = rdata_q;
    o_sqi_rdata_vld   = rdata_vld_q;
  end

endmodule
